aes_axis_frame_tx: RTL and testbench

- AXI4-Stream transmitter that builds command frames for the AES accelerator's slave port.
- Serialises each frame as: command word, optional 128-bit key, optional 128-bit IV, then N payload blocks of 128 bits, as a 32-bit stream with tlast on the final word.
- Sits between a host-side block source (DMA / test sequencer) and the accelerator's s00_axis input.

---
 rtl/aes_axis_frame_tx_pkg.sv | 53 +++++
 rtl/aes_blk_serializer.sv | 54 +++++
 rtl/aes_axis_frame_tx.sv | 189 ++++++++++++++++++
 tb/tb_aes_axis_frame_tx.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_axis_frame_tx_pkg.sv
// Shared constants, FSM encoding and section ordering for the AES frame transmitter.
package aes_axis_frame_tx_pkg;

   // 32-bit words per 128-bit AES item (state columns)
   localparam int NB     = 4;
   // Width of one stream word
   localparam int WORD_S = 32;
   // Width of one key, IV or payload block
   localparam int BLK_W  = NB * WORD_S;

   // Index of the final word of a 128-bit item
   localparam logic [1:0] LAST_WIDX = 2'(NB - 1);

   // Frame sections in transmission order; IDLE doubles as "frame finished"
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_KEY  = 3'd2,
      ST_IV   = 3'd3,
      ST_DATA = 3'd4
   } tx_state_t;

   // Section that follows the current one, given which optional sections are
   // enabled. This is the frame order the accelerator slave expects:
   // command, key, IV, payload. Returns ST_IDLE when nothing follows.
   function automatic tx_state_t next_section(input tx_state_t cur,
                                              input logic      key_en,
                                              input logic      iv_en,
                                              input logic      data_en);
      tx_state_t nxt;
      nxt = ST_IDLE;
      case (cur)
         ST_CMD: begin
            if (key_en)       nxt = ST_KEY;
            else if (iv_en)   nxt = ST_IV;
            else if (data_en) nxt = ST_DATA;
            else              nxt = ST_IDLE;
         end
         ST_KEY: begin
            if (iv_en)        nxt = ST_IV;
            else if (data_en) nxt = ST_DATA;
            else              nxt = ST_IDLE;
         end
         ST_IV: begin
            if (data_en)      nxt = ST_DATA;
            else              nxt = ST_IDLE;
         end
         default: nxt = ST_IDLE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/aes_blk_serializer.sv
// Holds one 128-bit item and presents it as four 32-bit words, MSW first.
// Reused for the key, IV and payload sections of a frame.
module aes_blk_serializer
   import aes_axis_frame_tx_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [BLK_W-1:0]  load_data,
   input  logic              ready,
   output logic              valid,
   output logic [WORD_S-1:0] word,
   output logic [1:0]        widx,
   output logic              last_hs
);

   logic [BLK_W-1:0] item;
   logic             hs;

   assign hs      = valid && ready;
   assign last_hs = hs && (widx == LAST_WIDX);

   // A load always wins so a new item can follow the final-word handshake of
   // the previous one with no bubble; otherwise the index steps on handshakes
   // and the item empties after its last word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         item  <= '0;
         valid <= 1'b0;
         widx  <= '0;
      end else if (load) begin
         item  <= load_data;
         valid <= 1'b1;
         widx  <= '0;
      end else if (hs) begin
         widx <= widx + 2'd1;
         if (widx == LAST_WIDX) begin
            valid <= 1'b0;
         end
      end
   end

   // Word select, most significant word first
   always_comb begin
      word = '0;
      case (widx)
         2'd0:    word = item[127:96];
         2'd1:    word = item[95:64];
         2'd2:    word = item[63:32];
         default: word = item[31:0];
      endcase
   end

endmodule

// File: rtl/aes_axis_frame_tx.sv
// AXI4-Stream transmitter building AES accelerator command frames:
// command word, optional key, optional IV, then N payload blocks.
module aes_axis_frame_tx
   import aes_axis_frame_tx_pkg::*;
#(
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int BLK_CNT_WIDTH        = 12
)
(
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   cmd,
   input  logic                              send_key,
   input  logic                              send_iv,
   input  logic [BLK_W-1:0]                  key,
   input  logic [BLK_W-1:0]                  iv,
   input  logic [BLK_CNT_WIDTH-1:0]          n_blks,
   input  logic [BLK_W-1:0]                  blk_data,
   input  logic                              blk_valid,
   output logic                              blk_ready,
   output logic                              m00_axis_tvalid,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                              m00_axis_tlast,
   input  logic                              m00_axis_tready,
   output logic                              busy,
   output logic                              done
);

   localparam logic [BLK_CNT_WIDTH-1:0] ONE_BLK = BLK_CNT_WIDTH'(1);

   tx_state_t state;
   tx_state_t state_nxt;
   tx_state_t follow;

   logic [C_M_AXIS_TDATA_WIDTH-1:0] cmd_q;
   logic [BLK_W-1:0]                key_q;
   logic [BLK_W-1:0]                iv_q;
   logic                            send_key_q;
   logic                            send_iv_q;
   logic [BLK_CNT_WIDTH-1:0]        remaining;
   logic                            has_data;
   logic                            blk_accept;

   logic                            ser_load;
   logic [BLK_W-1:0]                ser_load_data;
   logic                            ser_ready;
   logic                            ser_valid;
   logic [WORD_S-1:0]               ser_word;
   logic [1:0]                      ser_widx;
   logic                            ser_last_hs;

   assign m00_axis_tstrb = '1;
   assign busy           = (state != ST_IDLE);

   // Until DATA starts the counter still holds the latched n_blks, so the
   // same test answers "is there payload" and "are more blocks owed"
   assign has_data   = (remaining != '0);
   assign blk_accept = blk_valid && blk_ready;
   assign follow     = next_section(state, send_key_q, send_iv_q, has_data);

   // The serializer only sees the sink while one of its sections is active
   assign ser_ready = m00_axis_tready &&
                      ((state == ST_KEY) || (state == ST_IV) || (state == ST_DATA));

   aes_blk_serializer u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (ser_load),
      .load_data (ser_load_data),
      .ready     (ser_ready),
      .valid     (ser_valid),
      .word      (ser_word),
      .widx      (ser_widx),
      .last_hs   (ser_last_hs)
   );

   // Section state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture the whole frame description on an accepted start, then count
   // payload blocks down as the source hands them over
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_q      <= '0;
         key_q      <= '0;
         iv_q       <= '0;
         send_key_q <= 1'b0;
         send_iv_q  <= 1'b0;
         remaining  <= '0;
      end else if ((state == ST_IDLE) && start) begin
         cmd_q      <= cmd;
         key_q      <= key;
         iv_q       <= iv;
         send_key_q <= send_key;
         send_iv_q  <= send_iv;
         remaining  <= n_blks;
      end else if (blk_accept) begin
         remaining <= remaining - ONE_BLK;
      end
   end

   // done is the registered image of the tlast handshake, so it lands in the
   // first IDLE cycle where a new start can already be taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done <= 1'b0;
      end else begin
         done <= m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;
      end
   end

   // Next section, serializer loads, block handshake and stream outputs.
   // Key and IV are loaded on the final handshake of the preceding section so
   // their first word is on the bus the next cycle; payload always enters
   // through blk_ready, which costs the single bubble at the start of DATA.
   always_comb begin
      state_nxt       = state;
      ser_load        = 1'b0;
      ser_load_data   = '0;
      blk_ready       = 1'b0;
      m00_axis_tvalid = 1'b0;
      m00_axis_tdata  = '0;
      m00_axis_tlast  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_CMD;
            end
         end

         ST_CMD: begin
            m00_axis_tvalid = 1'b1;
            m00_axis_tdata  = cmd_q;
            m00_axis_tlast  = (follow == ST_IDLE);
            if (m00_axis_tready) begin
               state_nxt = follow;
               if (follow == ST_KEY) begin
                  ser_load      = 1'b1;
                  ser_load_data = key_q;
               end else if (follow == ST_IV) begin
                  ser_load      = 1'b1;
                  ser_load_data = iv_q;
               end
            end
         end

         ST_KEY, ST_IV: begin
            m00_axis_tvalid = ser_valid;
            m00_axis_tdata  = ser_valid ? ser_word : '0;
            m00_axis_tlast  = ser_valid && (ser_widx == LAST_WIDX) && (follow == ST_IDLE);
            if (ser_last_hs) begin
               state_nxt = follow;
               if (follow == ST_IV) begin
                  ser_load      = 1'b1;
                  ser_load_data = iv_q;
               end
            end
         end

         ST_DATA: begin
            m00_axis_tvalid = ser_valid;
            m00_axis_tdata  = ser_valid ? ser_word : '0;
            m00_axis_tlast  = ser_valid && (ser_widx == LAST_WIDX) && !has_data;
            blk_ready       = has_data && (!ser_valid || ser_last_hs);
            if (blk_accept) begin
               ser_load      = 1'b1;
               ser_load_data = blk_data;
            end
            if (ser_last_hs && !has_data) begin
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_aes_axis_frame_tx.sv
// Self-checking bench for aes_axis_frame_tx: table of frames plus hand-built
// sequences for start-while-busy, back-to-back frames and mid-frame reset.
module tb_aes_axis_frame_tx;

   localparam int BCW = 12;

   logic             clk;
   logic             reset;
   logic             start;
   logic [31:0]      cmd;
   logic             send_key;
   logic             send_iv;
   logic [127:0]     key;
   logic [127:0]     iv;
   logic [BCW-1:0]   n_blks;
   logic [127:0]     blk_data;
   logic             blk_valid;
   logic             blk_ready;
   logic             m00_axis_tvalid;
   logic [31:0]      m00_axis_tdata;
   logic [3:0]       m00_axis_tstrb;
   logic             m00_axis_tlast;
   logic             m00_axis_tready;
   logic             busy;
   logic             done;

   typedef struct {
      logic [31:0] cmd;
      bit          key_en;
      bit          iv_en;
      int          n;
      int          ready_mode;
      int          gap_after;
      int          exp_words;
      int          exp_span;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_word_t;

   exp_word_t    exp_q[$];
   logic [127:0] src_q[$];
   exp_word_t    mon_e;

   int n_cmp = 0;
   int n_err = 0;

   int ready_mode  = 0;
   int rdy_cyc     = 0;
   int gap_after   = -1;
   int gap_len     = 5;
   int gap_cnt     = 0;
   int blocks_sent = 0;
   int frame_id    = 0;

   int cyc         = 0;
   int frame_words = 0;
   int first_cyc   = 0;
   int end_cyc     = 0;
   int frames_done = 0;
   int last_words  = 0;
   int last_span   = 0;
   bit in_frame    = 0;
   bit prev_stall  = 0;
   bit prev_last_hs = 0;
   logic [31:0] prev_data;
   logic        prev_last;

   aes_axis_frame_tx #(
      .C_M_AXIS_TDATA_WIDTH (32),
      .BLK_CNT_WIDTH        (BCW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .cmd             (cmd),
      .send_key        (send_key),
      .send_iv         (send_iv),
      .key             (key),
      .iv              (iv),
      .n_blks          (n_blks),
      .blk_data        (blk_data),
      .blk_valid       (blk_valid),
      .blk_ready       (blk_ready),
      .m00_axis_tvalid (m00_axis_tvalid),
      .m00_axis_tdata  (m00_axis_tdata),
      .m00_axis_tstrb  (m00_axis_tstrb),
      .m00_axis_tlast  (m00_axis_tlast),
      .m00_axis_tready (m00_axis_tready),
      .busy            (busy),
      .done            (done)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the design wedges somewhere no bounded wait covers
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [127:0] make_blk(input logic [7:0] base);
      logic [127:0] b;
      b = '0;
      for (int j = 0; j < 16; j++) begin
         b[127 - 8*j -: 8] = base + 8'(j);
      end
      return b;
   endfunction

   task automatic pushExp(input logic [31:0] d, input bit l);
      exp_word_t w;
      w.data = d;
      w.last = l;
      exp_q.push_back(w);
   endtask

   // Builds the expected word stream for one frame, queues its payload blocks
   // at the source, pulses start, then scrambles the inputs to prove they
   // were latched.
   task automatic applyStimulus(input vec_t v);
      logic [127:0] k;
      logic [127:0] ivv;
      logic [127:0] b;
      logic [7:0]   fid;
      int           total;
      int           idx;
      k     = make_blk(8'h00);
      ivv   = make_blk(8'h10);
      fid   = 8'(frame_id);
      total = 1 + 4*int'(v.key_en) + 4*int'(v.iv_en) + 4*v.n;
      idx   = 0;
      ready_mode  = v.ready_mode;
      rdy_cyc     = 0;
      gap_after   = v.gap_after;
      gap_cnt     = 0;
      blocks_sent = 0;
      frame_words = 0;
      pushExp(v.cmd, idx == total - 1);
      idx++;
      if (v.key_en) begin
         for (int i = 0; i < 4; i++) begin
            pushExp(k[127 - 32*i -: 32], idx == total - 1);
            idx++;
         end
      end
      if (v.iv_en) begin
         for (int i = 0; i < 4; i++) begin
            pushExp(ivv[127 - 32*i -: 32], idx == total - 1);
            idx++;
         end
      end
      for (int bi = 0; bi < v.n; bi++) begin
         b = make_blk(8'hA0 + 8'(16*bi)) ^ {120'd0, fid};
         src_q.push_back(b);
         for (int i = 0; i < 4; i++) begin
            pushExp(b[127 - 32*i -: 32], idx == total - 1);
            idx++;
         end
      end
      cmd      = v.cmd;
      send_key = v.key_en;
      send_iv  = v.iv_en;
      key      = k;
      iv       = ivv;
      n_blks   = BCW'(v.n);
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      cmd      = ~v.cmd;
      send_key = ~v.key_en;
      send_iv  = ~v.iv_en;
      key      = ~k;
      iv       = ~ivv;
      n_blks   = ~BCW'(v.n);
      frame_id++;
   endtask

   // Waits (bounded) for the frame's tlast handshake; returns in the done cycle
   task automatic waitFrame(input int vid, input int exp_words, input int exp_span,
                            input int prev_done);
      int c;
      c = 0;
      while (frames_done == prev_done && c < 3000) begin
         @(posedge clk);
         c++;
      end
      #1;
      if (frames_done == prev_done) begin
         n_cmp++;
         n_err++;
         $display("[TB] FAIL frame%0d_timeout: got no tlast, expected frame end", vid);
      end else begin
         checkOutput($sformatf("frame%0d_words", vid), 64'(last_words), 64'(exp_words));
         if (exp_span != 0) begin
            checkOutput($sformatf("frame%0d_span", vid), 64'(last_span), 64'(exp_span));
         end
         checkOutput($sformatf("frame%0d_sb_empty", vid), 64'(exp_q.size()), 64'(0));
      end
   endtask

   // Block source: pops a block after each accepted handshake, optionally
   // withholding blk_valid for gap_len cycles after block gap_after
   initial begin
      bit acc;
      blk_valid = 1'b0;
      blk_data  = '0;
      forever begin
         @(negedge clk);
         acc = blk_valid && blk_ready && !reset;
         @(posedge clk);
         #1;
         if (acc && src_q.size() > 0) begin
            void'(src_q.pop_front());
            blocks_sent++;
            if (blocks_sent == gap_after) gap_cnt = gap_len;
         end
         if (gap_cnt > 0) begin
            blk_valid = 1'b0;
            gap_cnt--;
         end else if (src_q.size() > 0) begin
            blk_valid = 1'b1;
            blk_data  = src_q[0];
         end else begin
            blk_valid = 1'b0;
            blk_data  = '0;
         end
      end
   end

   // Sink: always ready, or the repeating 1,0,0,1 backpressure pattern
   initial begin
      m00_axis_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) begin
            m00_axis_tready = 1'b1;
         end else begin
            m00_axis_tready = ((rdy_cyc % 4) == 0) || ((rdy_cyc % 4) == 3);
            rdy_cyc++;
         end
      end
   end

   // Monitor: scoreboard pop on every handshake, stall stability, done pulse
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         in_frame     = 0;
         prev_stall   = 0;
         prev_last_hs = 0;
         frame_words  = 0;
      end else begin
         if (done || prev_last_hs) begin
            checkOutput("done_pulse", 64'(done), 64'(prev_last_hs));
         end
         if (prev_last_hs) begin
            checkOutput("busy_at_done", 64'(busy), 64'(0));
         end
         if (prev_stall) begin
            checkOutput("stall_tvalid", 64'(m00_axis_tvalid), 64'(1));
            checkOutput("stall_tdata", 64'(m00_axis_tdata), 64'(prev_data));
            checkOutput("stall_tlast", 64'(m00_axis_tlast), 64'(prev_last));
         end
         prev_last_hs = 0;
         if (m00_axis_tvalid && m00_axis_tready) begin
            if (!in_frame) begin
               in_frame    = 1;
               first_cyc   = cyc;
               frame_words = 0;
            end
            frame_words++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("[TB] FAIL sb_underflow: got word %0h, expected no word", m00_axis_tdata);
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("tdata", 64'(m00_axis_tdata), 64'(mon_e.data));
               checkOutput("tlast", 64'(m00_axis_tlast), 64'(mon_e.last));
            end
            if (m00_axis_tlast) begin
               prev_last_hs = 1;
               in_frame     = 0;
               last_words   = frame_words;
               last_span    = cyc - first_cyc + 1;
               end_cyc      = cyc;
               frames_done++;
            end
         end
         prev_stall = m00_axis_tvalid && !m00_axis_tready;
         prev_data  = m00_axis_tdata;
         prev_last  = m00_axis_tlast;
      end
   end

   initial begin
      vec_t vecs[7];
      vec_t v_rst;
      int   pd;
      int   a_end;
      int   c;

      vecs[0] = '{32'h00000001, 1'b1, 1'b1, 2, 0, -1, 17, 18};
      vecs[1] = '{32'hDEADBEEF, 1'b0, 1'b0, 0, 0, -1, 1, 1};
      vecs[2] = '{32'h00000003, 1'b0, 1'b0, 3, 1, -1, 13, 0};
      vecs[3] = '{32'h00000004, 1'b0, 1'b0, 3, 0, 1, 13, 16};
      vecs[4] = '{32'h00000005, 1'b1, 1'b0, 0, 0, -1, 5, 5};
      vecs[5] = '{32'h00000006, 1'b0, 1'b1, 1, 0, -1, 9, 10};
      vecs[6] = '{32'h00000007, 1'b1, 1'b1, 0, 1, -1, 9, 0};
      v_rst   = '{32'h00000008, 1'b0, 1'b0, 3, 0, -1, 13, 0};

      reset    = 1'b1;
      start    = 1'b0;
      cmd      = '0;
      send_key = 1'b0;
      send_iv  = 1'b0;
      key      = '0;
      iv       = '0;
      n_blks   = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_tvalid", 64'(m00_axis_tvalid), 64'(0));
      checkOutput("rst_tdata", 64'(m00_axis_tdata), 64'(0));
      checkOutput("rst_tlast", 64'(m00_axis_tlast), 64'(0));
      checkOutput("rst_tstrb", 64'(m00_axis_tstrb), 64'(4'hF));
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_done", 64'(done), 64'(0));
      checkOutput("rst_blk_ready", 64'(blk_ready), 64'(0));
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         $display("[TB] frame %0d cmd=%h", i, vecs[i].cmd);
         pd = frames_done;
         applyStimulus(vecs[i]);
         waitFrame(i, vecs[i].exp_words, vecs[i].exp_span, pd);
         repeat (2) @(posedge clk);
         #1;
      end

      $display("[TB] start while busy, then back-to-back start on done");
      pd = frames_done;
      applyStimulus(vecs[0]);
      repeat (3) @(posedge clk);
      #1;
      start    = 1'b1;
      cmd      = 32'hBAD0BAD0;
      send_key = 1'b0;
      send_iv  = 1'b0;
      n_blks   = '0;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitFrame(10, 17, 18, pd);
      a_end = end_cyc;
      checkOutput("b2b_busy_in_done_cycle", 64'(busy), 64'(0));
      pd = frames_done;
      applyStimulus(vecs[1]);
      waitFrame(11, 1, 1, pd);
      checkOutput("b2b_cmd_cycle", 64'(end_cyc - a_end), 64'(2));
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] reset during payload");
      applyStimulus(v_rst);
      c = 0;
      while (frame_words < 6 && c < 200) begin
         @(posedge clk);
         c++;
      end
      if (frame_words < 6) begin
         n_cmp++;
         n_err++;
         $display("[TB] FAIL reset_setup: got %0d words, expected 6", frame_words);
      end
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_tvalid", 64'(m00_axis_tvalid), 64'(0));
      checkOutput("async_rst_busy", 64'(busy), 64'(0));
      checkOutput("async_rst_blk_ready", 64'(blk_ready), 64'(0));
      checkOutput("async_rst_tstrb", 64'(m00_axis_tstrb), 64'(4'hF));
      exp_q.delete();
      src_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      pd = frames_done;
      applyStimulus(vecs[0]);
      waitFrame(20, 17, 18, pd);
      repeat (3) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
